// File: rtl/fb_pkg.sv
// Shared types and constants for the framebuffer writer.
package fb_pkg;

  localparam int ADDR_W = 16;
  localparam int PIX_W  = 8;

  // Luma weights; they sum to 256, so a 16-bit accumulator cannot overflow
  // and a grey input (v,v,v) maps back to exactly v.
  localparam logic [15:0] LUMA_R = 16'd77;
  localparam logic [15:0] LUMA_G = 16'd150;
  localparam logic [15:0] LUMA_B = 16'd29;

  // Writing the final address of the frame raises FRAME_DONE.
  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [PIX_W-1:0]  luma;
  } fb_entry_t;

  localparam int ENTRY_W = $bits(fb_entry_t);

  // 8-bit luma from 8-bit RGB: (77R + 150G + 29B) >> 8.
  function automatic logic [PIX_W-1:0] luma_of(input logic [PIX_W-1:0] r,
                                                input logic [PIX_W-1:0] g,
                                                input logic [PIX_W-1:0] b);
    logic [15:0] acc;
    acc = LUMA_R * {8'h00, r} + LUMA_G * {8'h00, g} + LUMA_B * {8'h00, b};
    return PIX_W'(acc >> 8);
  endfunction

endpackage

// File: rtl/fb_fifo.sv
// Show-ahead FIFO: rd_data_o always presents the head entry. A write while
// full is accepted only when a read happens on the same edge.
module fb_fifo
  import fb_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int WIDTH = ENTRY_W
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       wr_en_i,
  input  logic [WIDTH-1:0]           wr_data_i,
  input  logic                       rd_en_i,
  output logic [WIDTH-1:0]           rd_data_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     level_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
  localparam logic [LVL_W-1:0] LVL_ONE = LVL_W'(1);
  localparam logic [LVL_W-1:0] LVL_MAX = LVL_W'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic             do_wr, do_rd;

  assign empty_o   = (level_q == '0);
  assign full_o    = (level_q == LVL_MAX);
  assign level_o   = level_q;
  assign rd_data_o = mem_q[rd_ptr_q];

  // Qualify requests: no read from empty, no write to full unless a read frees a slot.
  always_comb begin
    do_rd = rd_en_i && !empty_o;
    do_wr = wr_en_i && (!full_o || do_rd);
  end

  // Pointer and occupancy next-state; pointers wrap modulo DEPTH (power of two).
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (do_wr) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (do_rd) rd_ptr_d = rd_ptr_q + PTR_ONE;
    case ({do_wr, do_rd})
      2'b10:   level_d = level_q + LVL_ONE;
      2'b01:   level_d = level_q - LVL_ONE;
      default: level_d = level_q;
    endcase
  end

  // Pointer/occupancy registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage array; contents are don't-care until written, so no reset.
  always_ff @(posedge clk_i) begin
    if (do_wr) mem_q[wr_ptr_q] <= wr_data_i;
  end

endmodule

// File: rtl/fb_writer.sv
// Framebuffer writer: detects new renderer pixels by a change of {Y,X},
// converts RGB to luma, buffers entries and drains them to the write port.
module fb_writer
  import fb_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [PIX_W-1:0]         x_i,
  input  logic [PIX_W-1:0]         y_i,
  input  logic [PIX_W-1:0]         r_i,
  input  logic [PIX_W-1:0]         g_i,
  input  logic [PIX_W-1:0]         b_i,
  input  logic                     wready_i,
  output logic                     we_o,
  output logic [ADDR_W-1:0]        waddr_o,
  output logic [PIX_W-1:0]         wdata_o,
  output logic                     frame_done_o,
  output logic                     overflow_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int LVL_W = $clog2(DEPTH) + 1;

  logic [ADDR_W-1:0]  pix_addr;
  logic [ADDR_W-1:0]  last_q, last_d;
  logic               primed_q, primed_d;
  logic               push;
  logic               pop;
  logic               overflow_q, overflow_d;
  logic               frame_done_q, frame_done_d;

  fb_entry_t          in_entry;
  fb_entry_t          head;
  logic [ENTRY_W-1:0] head_bits;
  logic               fifo_full, fifo_empty;
  logic [LVL_W-1:0]   fifo_level;

  assign pix_addr = {y_i, x_i};

  // Change detector: the first edge after reset only captures {Y,X};
  // afterwards any change of {Y,X} pushes, regardless of the colour inputs.
  always_comb begin
    primed_d = 1'b1;
    last_d   = pix_addr;
    push     = primed_q && (pix_addr != last_q);
  end

  // New entry: address plus combinational luma of the sampled colour.
  always_comb begin
    in_entry.addr = pix_addr;
    in_entry.luma = luma_of(r_i, g_i, b_i);
  end

  fb_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .wr_en_i   (push),
    .wr_data_i (in_entry),
    .rd_en_i   (pop),
    .rd_data_o (head_bits),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty),
    .level_o   (fifo_level)
  );

  assign head = head_bits;
  assign pop  = !fifo_empty && wready_i;

  // Drop detection and end-of-frame detection on the accepted write.
  always_comb begin
    overflow_d   = overflow_q || (push && fifo_full && !pop);
    frame_done_d = pop && (head.addr == LAST_ADDR);
  end

  // Detector, sticky overflow and frame-done registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      primed_q     <= 1'b0;
      last_q       <= '0;
      overflow_q   <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      primed_q     <= primed_d;
      last_q       <= last_d;
      overflow_q   <= overflow_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Write port presents the head entry; forced to zero while the FIFO is
  // empty so the port never shows stale storage contents.
  always_comb begin
    we_o    = !fifo_empty;
    waddr_o = fifo_empty ? '0 : head.addr;
    wdata_o = fifo_empty ? '0 : head.luma;
  end

  assign frame_done_o = frame_done_q;
  assign overflow_o   = overflow_q;
  assign level_o      = fifo_level;

endmodule

// File: tb/tb_fb_writer.sv
// Directed plus randomized bench for fb_writer with a queue-based reference model.
module tb_fb_writer;

  localparam int DEPTH = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] x, y, r, g, b;
  logic       wready;
  logic       we;
  logic [15:0] waddr;
  logic [7:0] wdata;
  logic       fd;
  logic       ovf;
  logic [3:0] level;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [23:0] q[$];
  bit          m_primed;
  logic [15:0] m_last;
  bit          m_ovf;
  bit          m_fd;

  fb_writer #(.DEPTH(DEPTH)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .x_i          (x),
    .y_i          (y),
    .r_i          (r),
    .g_i          (g),
    .b_i          (b),
    .wready_i     (wready),
    .we_o         (we),
    .waddr_o      (waddr),
    .wdata_o      (wdata),
    .frame_done_o (fd),
    .overflow_o   (ovf),
    .level_o      (level)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] model_luma(input int rr, input int gg, input int bb);
    int l;
    l = (77 * rr + 150 * gg + 29 * bb) / 256;
    return 8'(l);
  endfunction

  task automatic check_outputs();
    chk("we", 32'(we), 32'(q.size() != 0));
    chk("level", 32'(level), 32'(q.size()));
    chk("overflow", 32'(ovf), 32'(m_ovf));
    chk("frame_done", 32'(fd), 32'(m_fd));
    if (q.size() != 0) begin
      chk("waddr", 32'(waddr), 32'(q[0][23:8]));
      chk("wdata", 32'(wdata), 32'(q[0][7:0]));
    end
  endtask

  // One clock: update the model from the inputs sampled at the edge, then check.
  task automatic step();
    logic [15:0] a;
    bit          pop, push, full_b;
    @(posedge clk);
    if (rst) begin
      q.delete();
      m_primed = 0;
      m_last   = '0;
      m_ovf    = 0;
      m_fd     = 0;
    end else begin
      a      = {y, x};
      full_b = (q.size() == DEPTH);
      pop    = (q.size() != 0) && wready;
      push   = m_primed && (a != m_last);
      m_fd   = pop && (q[0][23:8] == 16'hFFFF);
      m_primed = 1;
      m_last   = a;
      if (pop) void'(q.pop_front());
      if (push) begin
        if (full_b && !pop) m_ovf = 1;
        else q.push_back({a, model_luma(int'(r), int'(g), int'(b))});
      end
    end
    #1;
    check_outputs();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic set_pix(input int yy, input int xx);
    y = 8'(yy);
    x = 8'(xx);
  endtask

  initial begin
    rst = 1'b1; x = 0; y = 0; r = 0; g = 0; b = 0; wready = 1'b0;

    // Reset values
    do_reset();
    chk("reset_waddr", 32'(waddr), 32'h0);
    chk("reset_wdata", 32'(wdata), 32'h0);

    // Unchanged {Y,X} with changing colour never pushes
    for (int i = 0; i < 20; i++) begin
      r = 8'($urandom); g = 8'($urandom); b = 8'($urandom);
      wready = 1'($urandom);
      step();
    end
    chk("static_xy_level", 32'(level), 32'h0);

    // Single grey pixel goes straight through
    do_reset();
    wready = 1'b1;
    set_pix(0, 0); step();
    set_pix(0, 1); r = 8'h80; g = 8'h80; b = 8'h80; step();
    chk("grey_we", 32'(we), 32'h1);
    chk("grey_addr", 32'(waddr), 32'h0001);
    chk("grey_luma", 32'(wdata), 32'h80);
    step();
    chk("grey_drained", 32'(level), 32'h0);

    // Fill while stalled, overflow on the ninth, then drain in order
    wready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      set_pix(1, 2 + i);
      r = 8'($urandom); g = 8'($urandom); b = 8'($urandom);
      step();
    end
    chk("full_level", 32'(level), 32'h8);
    chk("full_overflow", 32'(ovf), 32'h1);
    wready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      if (i < 8) chk("drain_order", 32'(waddr), 32'({8'd1, 8'(2 + i)}));
      step();
    end
    chk("drained_we", 32'(we), 32'h0);

    // Push and pop together while full: no overflow
    do_reset();
    wready = 1'b0;
    set_pix(2, 0); step();
    for (int i = 1; i <= 8; i++) begin
      set_pix(2, i); step();
    end
    set_pix(2, 9); wready = 1'b1; step();
    chk("pushpop_level", 32'(level), 32'h8);
    chk("pushpop_ovf", 32'(ovf), 32'h0);
    wready = 1'b1;
    for (int i = 0; i < 9; i++) step();

    // End-of-frame sweep with pure red
    do_reset();
    wready = 1'b1;
    r = 8'd255; g = 8'd0; b = 8'd0;
    set_pix(0, 5); step();
    set_pix(8'hFF, 8'hFE); step();
    chk("red_luma", 32'(wdata), 32'd76);
    set_pix(8'hFF, 8'hFF); step();
    set_pix(0, 0); step();
    chk("frame_done_pulse", 32'(fd), 32'h1);
    step();
    chk("frame_done_once", 32'(fd), 32'h0);

    // Reset mid-operation with five buffered pixels
    wready = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      set_pix(3, i); step();
    end
    chk("pre_reset_level", 32'(level), 32'h5);
    rst = 1'b1; step(); rst = 1'b0;
    chk("post_reset_level", 32'(level), 32'h0);
    chk("post_reset_we", 32'(we), 32'h0);
    set_pix(3, 40); step();
    chk("reprime_no_push", 32'(level), 32'h0);

    // Randomized traffic with repeats, stalls and overflow
    for (int i = 0; i < 400; i++) begin
      set_pix($urandom_range(0, 1), $urandom_range(0, 3));
      r = 8'($urandom); g = 8'($urandom); b = 8'($urandom);
      wready = (i < 200) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      rst = ($urandom_range(0, 99) == 0);
      step();
    end
    rst = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
